load_store_unit: RTL and testbench

//  Sits between the CPU datapath and the word-wide distributed_ram holding data memory.

---
 rtl/load_store_unit.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges the CPU datapath and a word-wide, asynchronously read data RAM.
// RV32I byte-addressed loads/stores (selected by funct3) become single word
// accesses. Sub-word loads pick the addressed lane and sign/zero extend.
// Sub-word stores read the word, merge the new lane(s) and write it back in
// the same cycle. Misaligned, out-of-range and illegal-funct3 requests are
// answered with resp_err=1 and never touch the RAM.
//
// Sequence: IDLE (accept) -> EXEC (one RAM cycle) -> RESP (hold until taken).
// An illegal request goes straight from IDLE to RESP.
//
// Ports
//   clk, rst       single clock, synchronous active-high reset
//   req_valid      request offered
//   req_ready      unit can accept (high only in IDLE)
//   req_write      1 = store, 0 = load
//   req_funct3     000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr       byte address
//   req_wdata      store data (low byte/half used for SB/SH)
//   resp_valid     response available
//   resp_ready     consumer takes the response
//   resp_rdata     extended load result; 0 for stores and errors
//   resp_err       misaligned, out-of-range or illegal funct3
//   ram_addr       RAM word index, held outside EXEC
//   ram_wr_ena     RAM write enable (EXEC of a store only)
//   ram_wr_data    merged word written to the RAM
//   ram_rd_data    combinational RAM read data at ram_addr
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned L         = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [$clog2(L)-1:0] ram_addr,
    output logic                 ram_wr_ena,
    output logic [31:0]          ram_wr_data,
    input  logic [31:0]          ram_rd_data
);

    localparam int unsigned AW   = $clog2(L);
    // Range bounds carry one extra bit so BASE_ADDR + 4*L cannot wrap to a
    // small value and wrongly admit high addresses.
    localparam logic [32:0] SPAN = 33'(L) << 2;
    localparam logic [32:0] LO   = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI   = LO + SPAN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // funct3 encodings that exist for the given direction
    function automatic logic funct3_ok(input logic wr, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~wr;   // no unsigned stores
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // natural alignment for the access size
    function automatic logic aligned_ok(input logic [2:0] f3, input logic [1:0] lo2);
        logic ok;
        case (f3)
            3'b001, 3'b101: ok = ~lo2[0];
            3'b010:         ok = (lo2 == 2'b00);
            default:        ok = 1'b1;
        endcase
        return ok;
    endfunction

    // BASE_ADDR <= addr < BASE_ADDR + 4*L, evaluated in 33 bits
    function automatic logic range_ok(input logic [31:0] a);
        logic [32:0] ax;
        ax = {1'b0, a};
        return (ax >= LO) && (ax < HI);
    endfunction

    // shift the addressed lane down and extend per funct3
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}},  sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b100:  res = {24'h00_0000,  sh[7:0]};
            3'b101:  res = {16'h0000,     sh[15:0]};
            default: res = sh;          // word: lane is always 0 here
        endcase
        return res;
    endfunction

    // replace the addressed lane(s) of the current word with store data
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] res;
        case (f3)
            3'b000: begin
                case (lane)
                    2'd0:    res = {word[31:8],  wd[7:0]};
                    2'd1:    res = {word[31:16], wd[7:0], word[7:0]};
                    2'd2:    res = {word[31:24], wd[7:0], word[15:0]};
                    default: res = {wd[7:0],     word[23:0]};
                endcase
            end
            3'b001: begin
                if (lane[1]) begin
                    res = {wd[15:0], word[15:0]};
                end else begin
                    res = {word[31:16], wd[15:0]};
                end
            end
            default: res = wd;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_r;
    logic            write_r;
    logic [2:0]      funct3_r;
    logic [1:0]      lane_r;
    logic [31:0]     wdata_r;
    logic [AW-1:0]   ram_addr_r;
    logic            wr_ena_r;
    logic            req_ready_r;
    logic            resp_valid_r;
    logic            resp_err_r;
    logic [31:0]     resp_rdata_r;

    logic            req_legal_s;
    logic [AW-1:0]   req_index_s;
    logic [31:0]     merge_s;

    // Legality and word index of the request currently offered
    always_comb begin
        req_legal_s = funct3_ok(req_write, req_funct3)
                    & aligned_ok(req_funct3, req_addr[1:0])
                    & range_ok(req_addr);
        req_index_s = AW'((req_addr - BASE_ADDR) >> 2);
    end

    // Read-modify-write word; only meaningful while a store is in EXEC
    always_comb begin
        if (wr_ena_r) begin
            merge_s = store_merge(ram_rd_data, wdata_r, funct3_r, lane_r);
        end else begin
            merge_s = 32'h0000_0000;
        end
    end

    // Control FSM with registered outputs and latched request fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            write_r      <= 1'b0;
            funct3_r     <= 3'b000;
            lane_r       <= 2'b00;
            wdata_r      <= 32'h0000_0000;
            ram_addr_r   <= '0;
            wr_ena_r     <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_r     <= req_write;
                        funct3_r    <= req_funct3;
                        lane_r      <= req_addr[1:0];
                        wdata_r     <= req_wdata;
                        req_ready_r <= 1'b0;
                        if (req_legal_s) begin
                            ram_addr_r <= req_index_s;
                            wr_ena_r   <= req_write;
                            state_r    <= ST_EXEC;
                        end else begin
                            // rejected: answer next cycle, RAM untouched
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                            state_r      <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    wr_ena_r     <= 1'b0;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    if (write_r) begin
                        resp_rdata_r <= 32'h0000_0000;
                    end else begin
                        resp_rdata_r <= load_extract(ram_rd_data, funct3_r, lane_r);
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    // req_ready rises only after the return to IDLE, so a
                    // request offered together with resp_ready waits a cycle
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'h0000_0000;
                        req_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    wr_ena_r     <= 1'b0;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    req_ready_r  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    // Reset cancels a write already lined up for this EXEC cycle
    always_comb begin
        ram_wr_ena  = wr_ena_r & ~rst;
        ram_wr_data = merge_s;
        ram_addr    = ram_addr_r;
        req_ready   = req_ready_r;
        resp_valid  = resp_valid_r;
        resp_err    = resp_err_r;
        resp_rdata  = resp_rdata_r;
    end

    load_store_unit_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .req_ready  (req_ready_r),
        .resp_valid (resp_valid_r),
        .resp_ready (resp_ready),
        .resp_err   (resp_err_r),
        .resp_rdata (resp_rdata_r),
        .ram_wr_ena (ram_wr_ena)
    );

endmodule

// -----------------------------------------------------------------------------
// load_store_unit_chk
// Protocol properties of load_store_unit: request and response sides are
// never both open, a RAM write lasts one cycle, and a stalled response holds.
// Ports mirror the like-named load_store_unit signals.
// -----------------------------------------------------------------------------
module load_store_unit_chk (
    input logic        clk,
    input logic        rst,
    input logic        req_ready,
    input logic        resp_valid,
    input logic        resp_ready,
    input logic        resp_err,
    input logic [31:0] resp_rdata,
    input logic        ram_wr_ena
);

    a_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(req_ready && resp_valid));

    a_single_write: assert property (@(posedge clk) disable iff (rst)
        ram_wr_ena |=> !ram_wr_ena);

    a_resp_hold: assert property (@(posedge clk) disable iff (rst)
        (resp_valid && !resp_ready) |=>
            (resp_valid && $stable(resp_rdata) && $stable(resp_err)));

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed load/store sequences against load_store_unit with a bench-owned
// word RAM. A byte-level reference model predicts every response and RAM
// update; literal values pin the model on the documented cases.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int          L    = 128;
    localparam int          AW   = $clog2(L);
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] ram_addr;
    logic          ram_wr_ena;
    logic [31:0]   ram_wr_data;
    logic [31:0]   ram_rd_data;

    logic [31:0]   mem       [0:L-1];
    logic [31:0]   model_mem [0:L-1];
    logic          mem_clr;

    int            n_pass  = 0;
    int            n_total = 0;

    // expectations published to the per-cycle compare process
    logic          chk_en    = 1'b0;
    logic          exp_err   = 1'b0;
    logic [31:0]   exp_rdata = 32'h0;
    logic          exp_store = 1'b0;
    logic [AW-1:0] exp_idx   = '0;
    logic [31:0]   exp_word  = 32'h0;

    load_store_unit #(.L(L), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .ram_addr    (ram_addr),
        .ram_wr_ena  (ram_wr_ena),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    // bench RAM: async read, write on posedge
    assign ram_rd_data = mem[ram_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < L; i++) mem[i] <= 32'h0;
        end else if (ram_wr_ena) begin
            mem[ram_addr] <= ram_wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    // Byte-level reference: legality from the RV32I rules, lanes as bytes
    task automatic model(input  logic w, input logic [2:0] f3, input logic [31:0] a,
                         input  logic [31:0] wd,
                         output logic err, output logic [31:0] rd,
                         output logic [AW-1:0] idx, output logic [31:0] nword);
        longint     off;
        int         size;
        int         lane;
        logic [7:0] b [4];
        logic [31:0] word;
        off  = longint'({32'h0, a}) - longint'({32'h0, BASE});
        size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        err  = 1'b0;
        if (f3 == 3'b011 || f3[2:1] == 2'b11) err = 1'b1;
        if (w && f3[2]) err = 1'b1;
        if ((a % size) != 0) err = 1'b1;
        if (off < 0 || off >= 4 * L) err = 1'b1;
        rd = 32'h0; idx = '0; nword = 32'h0;
        if (!err) begin
            idx  = AW'(off / 4);
            lane = int'(off % 4);
            word = model_mem[idx];
            for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
            if (w) begin
                for (int i = 0; i < size; i++) b[lane + i] = wd[8*i +: 8];
                nword = {b[3], b[2], b[1], b[0]};
                model_mem[idx] = nword;
            end else begin
                for (int i = 0; i < size; i++) rd[8*i +: 8] = b[lane + i];
                if (!f3[2] && size < 4 && rd[8*size - 1]) begin
                    for (int i = size; i < 4; i++) rd[8*i +: 8] = 8'hFF;
                end
            end
        end
    endtask

    // per-cycle compare of DUT outputs against the published expectation
    always @(negedge clk) begin
        if (chk_en && resp_valid) begin
            check("cmp resp_err",   32'(resp_err), 32'(exp_err));
            check("cmp resp_rdata", resp_rdata,    exp_rdata);
            check("cmp req_ready",  32'(req_ready), 32'd0);
        end
        if (ram_wr_ena) begin
            check("cmp write allowed", 32'(exp_store && chk_en && !rst), 32'd1);
            check("cmp ram_addr",      32'(ram_addr), 32'(exp_idx));
            check("cmp ram_wr_data",   ram_wr_data, exp_word);
        end
    end

    task automatic do_req(input string name, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic lit_err, input logic [31:0] lit_rd, input int stall);
        logic          m_err;
        logic [31:0]   m_rd;
        logic [AW-1:0] m_idx;
        logic [31:0]   m_word;
        int            lat;
        int            wr_cnt;
        logic          got;
        model(w, f3, a, wd, m_err, m_rd, m_idx, m_word);
        check({name, " model err"},   32'(m_err), 32'(lit_err));
        check({name, " model rdata"}, m_rd,       lit_rd);
        exp_err = m_err; exp_rdata = m_rd; exp_store = w && !m_err;
        exp_idx = m_idx; exp_word = m_word; chk_en = 1'b1;

        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = req_ready;
        end
        check({name, " accepted"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        // change every request field; the unit must use the latched copy
        req_valid = 1'b0; req_write = ~w; req_funct3 = 3'b010;
        req_addr = a ^ 32'h0000_0047; req_wdata = ~wd;

        lat = 0; wr_cnt = 0; got = 1'b0;
        for (int k = 1; k <= 6 && !got; k++) begin
            @(negedge clk);
            lat = k;
            if (ram_wr_ena) wr_cnt++;
            got = resp_valid;
        end
        check({name, " resp_valid"},  32'(got),    32'd1);
        check({name, " latency"},     32'(lat),    m_err ? 32'd1 : 32'd2);
        check({name, " write count"}, 32'(wr_cnt), exp_store ? 32'd1 : 32'd0);
        check({name, " rdata"},       resp_rdata,  m_rd);
        check({name, " err"},         32'(resp_err), 32'(m_err));

        if (stall > 0) begin
            // a competing request while the response is held must wait
            req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                check({name, " stall resp_valid"}, 32'(resp_valid), 32'd1);
                check({name, " stall req_ready"},  32'(req_ready),  32'd0);
            end
        end
        resp_ready = 1'b1;
        if (stall > 0) check({name, " release req_ready"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        resp_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check({name, " done resp_valid"}, 32'(resp_valid), 32'd0);
        check({name, " done req_ready"},  32'(req_ready),  32'd1);
        if (exp_store) check({name, " ram word"}, mem[m_idx], m_word);
        chk_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        for (int i = 0; i < L; i++) model_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;
        @(negedge clk);
        check("reset req_ready",  32'(req_ready),  32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_err",   32'(resp_err),   32'd0);
        check("reset resp_rdata", resp_rdata,      32'd0);
        check("reset ram_wr_ena", 32'(ram_wr_ena), 32'd0);
        check("reset ram_addr",   32'(ram_addr),   32'd0);
        @(posedge clk); #1 rst = 1'b0;

        do_req("SW 0x80",  1'b1, 3'b010, 32'h80, 32'hDEADBEEF, 1'b0, 32'h0, 0);
        check("lit word32 after SW", mem[32], 32'hDEADBEEF);
        do_req("LW 0x80",  1'b0, 3'b010, 32'h80, 32'h0, 1'b0, 32'hDEADBEEF, 0);
        do_req("SB 0x81",  1'b1, 3'b000, 32'h81, 32'h55, 1'b0, 32'h0, 0);
        check("lit word32 after SB", mem[32], 32'hDEAD55EF);
        do_req("LB 0x81",  1'b0, 3'b000, 32'h81, 32'h0, 1'b0, 32'h00000055, 0);
        do_req("LB 0x83",  1'b0, 3'b000, 32'h83, 32'h0, 1'b0, 32'hFFFFFFDE, 0);
        do_req("LBU 0x83", 1'b0, 3'b100, 32'h83, 32'h0, 1'b0, 32'h000000DE, 0);
        do_req("SH 0x82",  1'b1, 3'b001, 32'h82, 32'h1234ABCD, 1'b0, 32'h0, 0);
        check("lit word32 after SH", mem[32], 32'hABCD55EF);
        do_req("LH 0x82",  1'b0, 3'b001, 32'h82, 32'h0, 1'b0, 32'hFFFFABCD, 0);
        do_req("LHU 0x82", 1'b0, 3'b101, 32'h82, 32'h0, 1'b0, 32'h0000ABCD, 0);

        do_req("LW misaligned", 1'b0, 3'b010, 32'h82,       32'h0,  1'b1, 32'h0, 0);
        do_req("SH misaligned", 1'b1, 3'b001, 32'h81,       32'hFF, 1'b1, 32'h0, 0);
        do_req("LW 4*L",        1'b0, 3'b010, 32'h200,      32'h0,  1'b1, 32'h0, 0);
        do_req("LW top wrap",   1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,  1'b1, 32'h0, 0);
        do_req("SB funct3 100", 1'b1, 3'b100, 32'h80,       32'h77, 1'b1, 32'h0, 0);
        do_req("funct3 111",    1'b0, 3'b111, 32'h80,       32'h0,  1'b1, 32'h0, 0);
        check("lit word32 after errors", mem[32], 32'hABCD55EF);

        do_req("LW last word",  1'b0, 3'b010, 32'h1FC, 32'h0,  1'b0, 32'h0, 0);
        do_req("SB 0x1FF",      1'b1, 3'b000, 32'h1FF, 32'hA5, 1'b0, 32'h0, 0);
        check("lit word127 after SB", mem[127], 32'hA5000000);
        do_req("LB 0x1FF",      1'b0, 3'b000, 32'h1FF, 32'h0,  1'b0, 32'hFFFFFFA5, 0);

        do_req("LW stalled",    1'b0, 3'b010, 32'h80, 32'h0, 1'b0, 32'hABCD55EF, 5);

        // reset during EXEC of SW 0x10 must drop the write
        exp_store = 1'b0; exp_err = 1'b0; exp_rdata = 32'h0; chk_en = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'h1;
        @(negedge clk);
        check("rst-exec accepted", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst-exec wr_ena", 32'(ram_wr_ena), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst-exec req_ready",  32'(req_ready),  32'd1);
        check("rst-exec resp_valid", 32'(resp_valid), 32'd0);
        check("rst-exec word4",      mem[4],          model_mem[4]);
        check("rst-exec word4 lit",  mem[4],          32'h0);
        chk_en = 1'b0;

        do_req("LW after reset", 1'b0, 3'b010, 32'h80, 32'h0, 1'b0, 32'hABCD55EF, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
